c80486_bus_master: RTL and testbench
====================================

C80486_BUS_MASTER -- requirements
Module: c80486_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of T2 wait clocks before a cycle is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_addr in 30 (A31-A2), req_be_n in 4, req_wr in 1, req_mio in 1, req_dc in 1, req_burst in 1, req_wdata in 32.
REQ-005 SHALL have ports rsp_valid out 1, rsp_data out 32, rsp_last out 1, rsp_err out 1.
REQ-006 SHALL have 486-bus outputs b_ads_n 1, b_a 30, b_a_oe 1, b_be_n 4, b_m_ion 1, b_d_cn 1, b_w_rn 1, b_blast_n 1, b_d_out 32, b_d_oe 1, b_hlda 1.
REQ-007 SHALL have 486-bus inputs b_d_in 32, b_rdy_n 1, b_brdy_n 1, b_hold 1, b_boff_n 1.

Function
REQ-008 SHALL implement the states IDLE, T1, T2, HOLD and, per REQ-025, BOFF.
REQ-009 In IDLE, req_ready SHALL be 1 only when b_hold=0; a request SHALL be accepted when req_valid&req_ready, and the state SHALL then move to T1.
REQ-010 On acceptance, the block SHALL register all req_* fields; the registered fields SHALL remain stable until the cycle ends.
REQ-011 In T1, b_ads_n SHALL be 0 for exactly one clock, with b_a, b_be_n, b_m_ion, b_d_cn and b_w_rn valid, and b_a_oe=1; the next state SHALL be T2.
REQ-012 For a write, b_d_oe SHALL be 1 from T1 until the terminating ready, with b_d_out equal to req_wdata.
REQ-013 A burst SHALL be requested only for a read with req_burst=1; for a write, req_burst SHALL be ignored.
REQ-014 In T2, the beat SHALL end on the first clock where b_rdy_n=0 or b_brdy_n=0; if both are 0 in the same clock, b_rdy_n SHALL take precedence.
REQ-015 Burst beat address: b_a[1:0] SHALL equal the start A3:A2 XOR the beat index (0..3), giving the 486 line order; b_a[29:2] SHALL be held constant.
REQ-016 b_blast_n SHALL be 0 in T2 for a non-burst cycle and in beat 3 of a burst; otherwise it SHALL be 1.
REQ-017 Early burst termination: if the first beat ends with b_rdy_n=0, the cycle SHALL end after that single beat.
REQ-018 Every read beat SHALL produce one rsp_valid pulse in the clock after the ready is sampled, with rsp_data = b_d_in captured at the ready edge, and rsp_last=1 on the final beat.
REQ-019 A write SHALL produce one rsp_valid pulse with rsp_last=1 and rsp_data=0.
REQ-020 The wait counter SHALL clear at each beat start; if it reaches TIMEOUT without a ready, the cycle SHALL abort: rsp_valid=1, rsp_err=1, rsp_last=1, and the state SHALL return to IDLE.
REQ-021 From IDLE with b_hold=1, the state SHALL move to HOLD, with b_hlda=1 and b_a_oe=0 and b_d_oe=0 on the same clock; b_hold=0 SHALL return the state to IDLE with b_hlda=0 on the next clock.
REQ-022 b_hold asserted during T1 or T2 SHALL be honoured only after the cycle ends; a request pending at that point SHALL NOT be accepted until hold is released.

Reset
REQ-023 While rst=1, the outputs SHALL be: b_ads_n=1, b_blast_n=1, b_a_oe=0, b_d_oe=0, b_hlda=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_last=0; the state SHALL be IDLE and the counters 0.
REQ-024 An rst asserted mid-cycle SHALL abandon the cycle with no response; after rst falls, the first accepted request SHALL start a fresh T1.

Configuration
REQ-025 With C80486_BOFF_EN defined, b_boff_n=0 in T1 or T2 SHALL float the bus (b_a_oe=0, b_d_oe=0, b_ads_n=1) in the next clock and enter BOFF; b_boff_n=1 SHALL then restart the cycle at T1 from the first unfinished beat, keeping the burst beat index; beats already completed SHALL NOT produce a second response.
REQ-026 Without C80486_BOFF_EN, b_boff_n SHALL be ignored and the BOFF state SHALL NOT exist.

Structure
REQ-027 A shared package c80486_pkg SHALL hold the state enum, the burst-order function (XOR) and the beat-count constant 4.
REQ-028 The timeout counter SHALL be a sub-module c80486_wait_timer with inputs clr and tick and output expired.

Verification
REQ-029 Single read, addr 0x0000100, b_rdy_n low after 2 waits -> b_ads_n low for 1 clock, b_blast_n=0, rsp_data=0xDEADBEEF, rsp_last=1.
REQ-030 Burst read, start A3:A2=2, b_brdy_n 4 times -> b_a[1:0] sequence 2,3,0,1, b_blast_n=0 only on beat 4, 4 responses with rsp_last on the 4th.
REQ-031 Burst read whose first beat ends with b_rdy_n -> exactly 1 response with rsp_last=1.
REQ-032 Write 0x12345678 with b_be_n=0x3 -> b_d_oe=1 T1..ready, b_w_rn=1, 1 response with rsp_err=0.
REQ-033 No ready for 255 clocks -> rsp_err=1, state IDLE; b_hold during T2 -> b_hlda rises only after the terminating ready.
REQ-034 With C80486_BOFF_EN, b_boff_n low in burst beat 2 for 3 clocks -> bus floated, restart at beat index 1, total 4 responses.

Source files
------------

// File: rtl/c80486_pkg.sv
// Shared types and helpers for the c80486 bus master.
// ST_BOFF only exists when C80486_BOFF_EN is defined.
package c80486_pkg;

  localparam int unsigned BEAT_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_HOLD = 3'd3
`ifdef C80486_BOFF_EN
    , ST_BOFF = 3'd4
`endif
  } state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be_n;
    logic        wr;
    logic        mio;
    logic        dc;
    logic        burst;
    logic [31:0] wdata;
  } req_t;

  // 486 cache-line order: the beat index flips the low address bits.
  function automatic logic [1:0] burst_addr(input logic [1:0] start, input logic [1:0] beat);
    return start ^ beat;
  endfunction

endpackage

// File: rtl/c80486_bus_master_if.sv
// Request/response handshake and 486 bus pins of the c80486 bus master.
interface c80486_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [29:0] req_addr;
  logic [3:0]  req_be_n;
  logic        req_wr;
  logic        req_mio;
  logic        req_dc;
  logic        req_burst;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;

  logic        b_ads_n;
  logic [29:0] b_a;
  logic        b_a_oe;
  logic [3:0]  b_be_n;
  logic        b_m_ion;
  logic        b_d_cn;
  logic        b_w_rn;
  logic        b_blast_n;
  logic [31:0] b_d_out;
  logic        b_d_oe;
  logic        b_hlda;
  logic [31:0] b_d_in;
  logic        b_rdy_n;
  logic        b_brdy_n;
  logic        b_hold;
  logic        b_boff_n;

  modport master (
    input  req_valid, req_addr, req_be_n, req_wr, req_mio, req_dc, req_burst, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
    output b_ads_n, b_a, b_a_oe, b_be_n, b_m_ion, b_d_cn, b_w_rn, b_blast_n,
    output b_d_out, b_d_oe, b_hlda,
    input  b_d_in, b_rdy_n, b_brdy_n, b_hold, b_boff_n
  );

  modport slave (
    output req_valid, req_addr, req_be_n, req_wr, req_mio, req_dc, req_burst, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
    input  b_ads_n, b_a, b_a_oe, b_be_n, b_m_ion, b_d_cn, b_w_rn, b_blast_n,
    input  b_d_out, b_d_oe, b_hlda,
    output b_d_in, b_rdy_n, b_brdy_n, b_hold, b_boff_n
  );
endinterface

// File: rtl/c80486_wait_timer.sv
// Counts T2 wait clocks; expired is high once LIMIT-1 waits have elapsed,
// so the next unanswered wait clock is the LIMIT-th one.
module c80486_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;
  logic         expired_r;

  // Next count: clear wins, then saturating increment.
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = {W{1'b0}};
    end else if (tick && !expired_r) begin
      count_nxt_s = count_r + 1'b1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Counter and registered expiry flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= {W{1'b0}};
      expired_r <= (LAST == {W{1'b0}});
    end else begin
      count_r   <= count_nxt_s;
      expired_r <= (count_nxt_s == LAST);
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/c80486_bus_master.sv
// 486 bus master: single/burst cycles, hold/hlda, wait timeout.
// Define C80486_BOFF_EN to add the BOFF# back-off state.
module c80486_bus_master
  import c80486_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  c80486_bus_master_if.master        bus
);

  state_e      state_r, state_nxt_s;
  req_t        req_r, req_nxt_s;
  logic [1:0]  beat_r, beat_nxt_s;
  logic        ready_s, accept_s, rdy_s, brdy_s, in_bus_s;
  logic        rsp_fire_s, rsp_last_s, rsp_err_s, tick_s, clr_s, expired_s;
  logic        b_ads_n_r, b_blast_n_r, b_a_oe_r, b_d_oe_r, b_hlda_r;
  logic [29:0] b_a_r;
  logic        rsp_valid_r, rsp_last_r, rsp_err_r;
  logic [31:0] rsp_data_r;

  assign ready_s  = (state_r == ST_IDLE) && !bus.b_hold && !rst;
  assign accept_s = ready_s && bus.req_valid;
  assign rdy_s    = !bus.b_rdy_n;
  assign brdy_s   = !bus.b_brdy_n;
  assign in_bus_s = (state_nxt_s == ST_T1) || (state_nxt_s == ST_T2);

  c80486_wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .tick    (tick_s),
    .expired (expired_s)
  );

  // Request fields are frozen from acceptance until the cycle ends.
  always_comb begin
    req_nxt_s = req_r;
    if (accept_s) begin
      req_nxt_s.addr  = bus.req_addr;
      req_nxt_s.be_n  = bus.req_be_n;
      req_nxt_s.wr    = bus.req_wr;
      req_nxt_s.mio   = bus.req_mio;
      req_nxt_s.dc    = bus.req_dc;
      req_nxt_s.burst = bus.req_burst && !bus.req_wr;
      req_nxt_s.wdata = bus.req_wdata;
    end else begin
      req_nxt_s = req_r;
    end
  end

  // Next state, beat index, response strobes and wait-timer control.
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    rsp_fire_s  = 1'b0;
    rsp_last_s  = 1'b0;
    rsp_err_s   = 1'b0;
    tick_s      = 1'b0;
    clr_s       = 1'b0;
`ifdef C80486_BOFF_EN
    if (!bus.b_boff_n && ((state_r == ST_T1) || (state_r == ST_T2))) begin
      state_nxt_s = ST_BOFF;
    end else
`endif
    begin
      case (state_r)
        ST_IDLE: begin
          if (bus.b_hold) begin
            state_nxt_s = ST_HOLD;
          end else if (accept_s) begin
            state_nxt_s = ST_T1;
            beat_nxt_s  = 2'd0;
            clr_s       = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (bus.b_hold) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_T1: state_nxt_s = ST_T2;
        ST_T2: begin
          if (rdy_s || brdy_s) begin
            rsp_fire_s = 1'b1;
            // RDY# always terminates; BRDY# only on the last line beat.
            if (rdy_s || !req_r.burst || (beat_r == 2'd3)) begin
              rsp_last_s  = 1'b1;
              state_nxt_s = bus.b_hold ? ST_HOLD : ST_IDLE;
            end else begin
              beat_nxt_s = beat_r + 2'd1;
              clr_s      = 1'b1;
            end
          end else if (expired_s) begin
            rsp_fire_s  = 1'b1;
            rsp_last_s  = 1'b1;
            rsp_err_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            tick_s = 1'b1;
          end
        end
`ifdef C80486_BOFF_EN
        ST_BOFF: begin
          if (bus.b_boff_n) begin
            state_nxt_s = ST_T1;
            clr_s       = 1'b1;
          end else begin
            state_nxt_s = ST_BOFF;
          end
        end
`endif
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, beat index and captured request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      beat_r  <= 2'd0;
      req_r   <= {$bits(req_t){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      beat_r  <= beat_nxt_s;
      req_r   <= req_nxt_s;
    end
  end

  // Bus pins are loaded from next-state values so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_ads_n_r   <= 1'b1;
      b_blast_n_r <= 1'b1;
      b_a_oe_r    <= 1'b0;
      b_d_oe_r    <= 1'b0;
      b_hlda_r    <= 1'b0;
      b_a_r       <= 30'd0;
    end else begin
      b_ads_n_r   <= (state_nxt_s != ST_T1);
      b_blast_n_r <= !((state_nxt_s == ST_T2) && (!req_nxt_s.burst || (beat_nxt_s == 2'd3)));
      b_a_oe_r    <= in_bus_s;
      b_d_oe_r    <= in_bus_s && req_nxt_s.wr;
      b_hlda_r    <= (state_nxt_s == ST_HOLD);
      b_a_r       <= {req_nxt_s.addr[29:2], burst_addr(req_nxt_s.addr[1:0], beat_nxt_s)};
    end
  end

  // One-clock response pulse after each terminated beat or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= 32'd0;
    end else begin
      rsp_valid_r <= rsp_fire_s;
      rsp_last_r  <= rsp_last_s;
      rsp_err_r   <= rsp_err_s;
      rsp_data_r  <= (rsp_fire_s && !req_r.wr && !rsp_err_s) ? bus.b_d_in : 32'd0;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_last  = rsp_last_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.b_ads_n   = b_ads_n_r;
  assign bus.b_a       = b_a_r;
  assign bus.b_a_oe    = b_a_oe_r;
  assign bus.b_be_n    = req_r.be_n;
  assign bus.b_m_ion   = req_r.mio;
  assign bus.b_d_cn    = req_r.dc;
  assign bus.b_w_rn    = req_r.wr;
  assign bus.b_blast_n = b_blast_n_r;
  assign bus.b_d_out   = req_r.wdata;
  assign bus.b_d_oe    = b_d_oe_r;
  assign bus.b_hlda    = b_hlda_r;

endmodule

// File: tb/tb_c80486_bus_master.sv
// Directed self-checking bench for c80486_bus_master (BOFF section when C80486_BOFF_EN is defined).
module tb_c80486_bus_master;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  c80486_bus_master_if bus ();

  c80486_bus_master #(.TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_tests++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [29:0] addr, input logic [3:0] be_n, input logic wr,
                         input logic burst, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_be_n  = be_n;
    bus.req_wr    = wr;
    bus.req_mio   = 1'b1;
    bus.req_dc    = 1'b1;
    bus.req_burst = burst;
    bus.req_wdata = wdata;
  endtask

  initial begin
    int n;
    logic [1:0] seq [4];

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = 30'd0; bus.req_be_n = 4'hF; bus.req_wr = 1'b0;
    bus.req_mio = 1'b0; bus.req_dc = 1'b0; bus.req_burst = 1'b0; bus.req_wdata = 32'd0;
    bus.b_d_in = 32'd0; bus.b_rdy_n = 1'b1; bus.b_brdy_n = 1'b1; bus.b_hold = 1'b0; bus.b_boff_n = 1'b1;
    tick(); tick();
    check("rst_ads_n",   bus.b_ads_n,   32'd1);
    check("rst_blast_n", bus.b_blast_n, 32'd1);
    check("rst_a_oe",    bus.b_a_oe,    32'd0);
    check("rst_d_oe",    bus.b_d_oe,    32'd0);
    check("rst_hlda",    bus.b_hlda,    32'd0);
    check("rst_ready",   bus.req_ready, 32'd0);
    check("rst_rsp",     {bus.rsp_valid, bus.rsp_err, bus.rsp_last}, 32'd0);
    rst = 1'b0;
    #1 check("idle_ready", bus.req_ready, 32'd1);

    // Single read, ready after two wait clocks
    request(30'h0000100, 4'h0, 1'b0, 1'b0, 32'd0);
    tick(); bus.req_valid = 1'b0;
    check("rd_t1_ads_n", bus.b_ads_n,   32'd0);
    check("rd_t1_addr",  bus.b_a,       32'h100);
    check("rd_t1_a_oe",  bus.b_a_oe,    32'd1);
    check("rd_t1_blast", bus.b_blast_n, 32'd1);
    check("rd_t1_ctl",   {bus.b_w_rn, bus.b_m_ion, bus.b_d_cn}, 32'd3);
    tick();
    check("rd_t2_ads_n", bus.b_ads_n,   32'd1);
    check("rd_t2_blast", bus.b_blast_n, 32'd0);
    tick(); tick();
    check("rd_wait_rsp", bus.rsp_valid, 32'd0);
    bus.b_rdy_n = 1'b0; bus.b_d_in = 32'hDEADBEEF;
    tick();
    bus.b_rdy_n = 1'b1; bus.b_d_in = 32'd0;
    check("rd_rsp_valid", bus.rsp_valid, 32'd1);
    check("rd_rsp_data",  bus.rsp_data,  32'hDEADBEEF);
    check("rd_rsp_last",  bus.rsp_last,  32'd1);
    check("rd_rsp_err",   bus.rsp_err,   32'd0);
    check("rd_end_a_oe",  bus.b_a_oe,    32'd0);
    tick();
    check("rd_rsp_pulse", bus.rsp_valid, 32'd0);

    // Burst read starting at A3:A2 = 2
    seq[0] = 2'd2; seq[1] = 2'd3; seq[2] = 2'd0; seq[3] = 2'd1;
    request(30'h0000202, 4'h0, 1'b0, 1'b1, 32'd0);
    tick(); bus.req_valid = 1'b0;
    check("bst_t1_ads_n", bus.b_ads_n, 32'd0);
    check("bst_t1_addr",  bus.b_a,     32'h202);
    tick();
    bus.b_brdy_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bst_addr",  bus.b_a,       {2'b00, 28'h0000080, seq[i]});
      check("bst_blast", bus.b_blast_n, (i == 3) ? 32'd0 : 32'd1);
      bus.b_d_in = 32'hA5A50000 + 32'(i);
      tick();
      check("bst_rsp_valid", bus.rsp_valid, 32'd1);
      check("bst_rsp_data",  bus.rsp_data,  32'hA5A50000 + 32'(i));
      check("bst_rsp_last",  bus.rsp_last,  (i == 3) ? 32'd1 : 32'd0);
    end
    bus.b_brdy_n = 1'b1;
    tick();
    check("bst_done_rsp",  bus.rsp_valid, 32'd0);
    check("bst_done_a_oe", bus.b_a_oe,    32'd0);

    // Burst read cut short by RDY# (with BRDY# also low) on the first beat
    request(30'h0000300, 4'h0, 1'b0, 1'b1, 32'd0);
    tick(); bus.req_valid = 1'b0;
    tick();
    check("eb_blast", bus.b_blast_n, 32'd1);
    bus.b_rdy_n = 1'b0; bus.b_brdy_n = 1'b0; bus.b_d_in = 32'h0BADF00D;
    tick();
    bus.b_rdy_n = 1'b1; bus.b_brdy_n = 1'b1;
    check("eb_rsp_valid", bus.rsp_valid, 32'd1);
    check("eb_rsp_data",  bus.rsp_data,  32'h0BADF00D);
    check("eb_rsp_last",  bus.rsp_last,  32'd1);
    tick();
    check("eb_no_more",   bus.rsp_valid, 32'd0);
    check("eb_idle",      bus.req_ready, 32'd1);

    // Write with burst request ignored
    request(30'h0000040, 4'h3, 1'b1, 1'b1, 32'h12345678);
    tick(); bus.req_valid = 1'b0;
    check("wr_t1_ads_n", bus.b_ads_n, 32'd0);
    check("wr_t1_d_oe",  bus.b_d_oe,  32'd1);
    check("wr_w_rn",     bus.b_w_rn,  32'd1);
    check("wr_d_out",    bus.b_d_out, 32'h12345678);
    check("wr_be_n",     bus.b_be_n,  32'h3);
    tick();
    check("wr_t2_d_oe",  bus.b_d_oe,    32'd1);
    check("wr_t2_blast", bus.b_blast_n, 32'd0);
    bus.b_brdy_n = 1'b0;
    tick();
    bus.b_brdy_n = 1'b1;
    check("wr_rsp_valid", bus.rsp_valid, 32'd1);
    check("wr_rsp_last",  bus.rsp_last,  32'd1);
    check("wr_rsp_err",   bus.rsp_err,   32'd0);
    check("wr_rsp_data",  bus.rsp_data,  32'd0);
    check("wr_end_d_oe",  bus.b_d_oe,    32'd0);
    tick();
    check("wr_rsp_pulse", bus.rsp_valid, 32'd0);

    // Timeout: no ready at all, abort after 255 T2 wait clocks
    request(30'h0000010, 4'h0, 1'b0, 1'b0, 32'd0);
    tick(); bus.req_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("to_clocks", 32'(n), 32'd256);
    check("to_err",    bus.rsp_err,   32'd1);
    check("to_last",   bus.rsp_last,  32'd1);
    check("to_idle",   bus.req_ready, 32'd1);
    tick();

    // Hold from IDLE
    bus.b_hold = 1'b1;
    #1 check("ih_ready", bus.req_ready, 32'd0);
    tick();
    check("ih_hlda", bus.b_hlda, 32'd1);
    check("ih_a_oe", bus.b_a_oe, 32'd0);
    bus.b_hold = 1'b0;
    tick();
    check("ih_release", bus.b_hlda,    32'd0);
    check("ih_ready2",  bus.req_ready, 32'd1);

    // Hold raised in T2 is deferred until the terminating ready
    request(30'h0000020, 4'h0, 1'b0, 1'b0, 32'd0);
    tick(); bus.req_valid = 1'b0;
    tick();
    bus.b_hold = 1'b1;
    tick();
    check("hd_wait_hlda", bus.b_hlda, 32'd0);
    check("hd_wait_a_oe", bus.b_a_oe, 32'd1);
    request(30'h0000024, 4'h0, 1'b0, 1'b0, 32'd0);
    bus.b_rdy_n = 1'b0; bus.b_d_in = 32'h5555AAAA;
    tick();
    bus.b_rdy_n = 1'b1;
    check("hd_rsp",  bus.rsp_valid, 32'd1);
    check("hd_hlda", bus.b_hlda,    32'd1);
    check("hd_a_oe", bus.b_a_oe,    32'd0);
    check("hd_d_oe", bus.b_d_oe,    32'd0);
    tick();
    check("hd_pending_ready", bus.req_ready, 32'd0);
    check("hd_hlda_stay",     bus.b_hlda,    32'd1);
    bus.b_hold = 1'b0;
    tick();
    check("hd_hlda_drop", bus.b_hlda,    32'd0);
    check("hd_resume",    bus.req_ready, 32'd1);
    tick(); bus.req_valid = 1'b0;
    check("hd_t1_ads_n", bus.b_ads_n, 32'd0);
    check("hd_t1_addr",  bus.b_a,     32'h24);
    tick();
    bus.b_rdy_n = 1'b0;
    tick();
    bus.b_rdy_n = 1'b1;
    check("hd_pend_rsp", bus.rsp_valid, 32'd1);
    tick();

    // Reset in the middle of a cycle
    request(30'h0000044, 4'h0, 1'b0, 1'b0, 32'd0);
    tick(); bus.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mr_ads_n",  bus.b_ads_n,   32'd1);
    check("mr_a_oe",   bus.b_a_oe,    32'd0);
    check("mr_blast",  bus.b_blast_n, 32'd1);
    check("mr_ready",  bus.req_ready, 32'd0);
    tick();
    rst = 1'b0;
    bus.b_rdy_n = 1'b0; bus.b_d_in = 32'h00001234;
    tick();
    bus.b_rdy_n = 1'b1;
    check("mr_no_rsp", bus.rsp_valid, 32'd0);
    request(30'h0000048, 4'h0, 1'b0, 1'b0, 32'd0);
    tick(); bus.req_valid = 1'b0;
    check("mr_t1_ads_n", bus.b_ads_n, 32'd0);
    check("mr_t1_addr",  bus.b_a,     32'h48);
    tick();
    bus.b_rdy_n = 1'b0; bus.b_d_in = 32'hCAFE0048;
    tick();
    bus.b_rdy_n = 1'b1;
    check("mr_rsp_data", bus.rsp_data, 32'hCAFE0048);
    tick();

`ifdef C80486_BOFF_EN
    // Back-off during beat index 1 of a burst starting at A3:A2 = 1
    seq[0] = 2'd1; seq[1] = 2'd0; seq[2] = 2'd3; seq[3] = 2'd2;
    n = 0;
    request(30'h0000101, 4'h0, 1'b0, 1'b1, 32'd0);
    tick(); bus.req_valid = 1'b0;
    tick();
    bus.b_brdy_n = 1'b0; bus.b_d_in = 32'hB0B00000;
    tick();
    if (bus.rsp_valid === 1'b1) n++;
    check("bo_rsp0", bus.rsp_data, 32'hB0B00000);
    bus.b_brdy_n = 1'b1; bus.b_boff_n = 1'b0;
    tick();
    check("bo_a_oe", bus.b_a_oe,    32'd0);
    check("bo_ads_n", bus.b_ads_n,  32'd1);
    check("bo_d_oe", bus.b_d_oe,    32'd0);
    tick(); tick();
    check("bo_hold_rsp", bus.rsp_valid, 32'd0);
    bus.b_boff_n = 1'b1;
    tick();
    check("bo_restart_ads", bus.b_ads_n, 32'd0);
    check("bo_restart_a",   bus.b_a,     {2'b00, 28'h0000040, seq[1]});
    tick();
    bus.b_brdy_n = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("bo_addr", bus.b_a, {2'b00, 28'h0000040, seq[i]});
      bus.b_d_in = 32'hB0B00000 + 32'(i);
      tick();
      if (bus.rsp_valid === 1'b1) n++;
      check("bo_rsp_data", bus.rsp_data, 32'hB0B00000 + 32'(i));
      check("bo_rsp_last", bus.rsp_last, (i == 3) ? 32'd1 : 32'd0);
    end
    bus.b_brdy_n = 1'b1;
    tick();
    if (bus.rsp_valid === 1'b1) n++;
    check("bo_total_rsp", 32'(n), 32'd4);
`else
    // BOFF# has no effect in this build
    request(30'h00000C0, 4'h0, 1'b0, 1'b0, 32'd0);
    tick(); bus.req_valid = 1'b0;
    bus.b_boff_n = 1'b0;
    tick();
    check("nb_a_oe",  bus.b_a_oe,  32'd1);
    check("nb_ads_n", bus.b_ads_n, 32'd1);
    bus.b_rdy_n = 1'b0; bus.b_d_in = 32'h000000C0;
    tick();
    bus.b_rdy_n = 1'b1; bus.b_boff_n = 1'b1;
    check("nb_rsp",  bus.rsp_valid, 32'd1);
    check("nb_data", bus.rsp_data,  32'h000000C0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
